// File: rtl/bit_balance_monitor.sv
// rtl/bit_balance_monitor.sv - two-stage popcount / running-disparity monitor with windowed alarm
// Optional feature macro: BITBAL_STICKY_ALARM_EN (sticky alarm with alarm_clr input)
module bit_balance_monitor #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 8,
    parameter int DW     = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef BITBAL_STICKY_ALARM_EN
    input  logic                 alarm_clr,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_count,
    output logic signed [DW-1:0] out_disp,
    output logic                 out_last,
    output logic                 alarm
);

    // Extended arithmetic width: wide enough for accumulator plus any per-word disparity
    localparam int EW   = ((DW > CW) ? DW : CW) + 3;
    localparam int WINW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WINW-1:0] WIN_LAST = WINW'(WINDOW - 1);

    logic                 s1_valid;
    logic [CW-1:0]        s1_count;
    logic [CW-1:0]        pc;
    logic                 s2_ready;
    logic                 s2_load;
    logic                 accept;
    logic signed [DW-1:0] acc;
    logic [WINW-1:0]      wcnt;
    logic                 over_r;

    logic signed [EW-1:0] d_ext;
    logic signed [EW-1:0] acc_ext;
    logic signed [EW-1:0] sum_ext;
    logic signed [EW-1:0] sat_ext;
    logic signed [EW-1:0] abs_ext;
    logic signed [EW-1:0] sat_max;
    logic signed [EW-1:0] sat_min;
    logic                 over_n;
    logic                 win_end;

    // S2 can take a word when it is empty or its result is leaving this cycle
    assign s2_ready = !out_valid || out_ready;
    assign s2_load  = s1_valid && s2_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign accept   = in_valid && in_ready;
    assign win_end  = (wcnt == WIN_LAST);

    // Population count of the incoming word
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + CW'(in_data[i]);
        end
    end

    // Per-word disparity, saturating accumulation and threshold test
    always_comb begin
        d_ext   = $signed(EW'({s1_count, 1'b0})) - $signed(EW'(WIDTH));
        acc_ext = {{(EW-DW){acc[DW-1]}}, acc};
        sum_ext = acc_ext + d_ext;
        sat_max = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        sat_min = -sat_max;
        sat_ext = sum_ext;
        if (sum_ext > sat_max) begin
            sat_ext = sat_max;
        end else if (sum_ext < sat_min) begin
            sat_ext = sat_min;
        end
        abs_ext = (sat_ext < 0) ? -sat_ext : sat_ext;
        over_n  = (64'(abs_ext) > 64'(THRESH));
    end

    // Stage 1: hold the popcount of the accepted word
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_count <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_count <= pc;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result registers, window accumulator and window counter
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_disp  <= '0;
            out_last  <= 1'b0;
            over_r    <= 1'b0;
            acc       <= '0;
            wcnt      <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_count <= s1_count;
            out_disp  <= sat_ext[DW-1:0];
            over_r    <= over_n;
            out_last  <= win_end;
            if (win_end) begin
                acc  <= '0;
                wcnt <= '0;
            end else begin
                acc  <= sat_ext[DW-1:0];
                wcnt <= wcnt + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BITBAL_STICKY_ALARM_EN
    logic alarm_st;

    // Sticky alarm: set by any transferred over-threshold result, set beats clear
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_st <= 1'b0;
        end else if (out_valid && out_ready && over_r) begin
            alarm_st <= 1'b1;
        end else if (alarm_clr) begin
            alarm_st <= 1'b0;
        end
    end

    assign alarm = alarm_st;
`else
    assign alarm = out_valid && over_r;
`endif

endmodule

// File: tb/tb_bit_balance_monitor.sv
// tb/tb_bit_balance_monitor.sv - scoreboard bench for bit_balance_monitor
module tb_bit_balance_monitor;

    typedef struct {
        int count;
        int disp;
        bit last;
        bit alarm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       out_count;
    logic signed [7:0] out_disp;
    logic             out_last;
    logic             alarm;

    logic             in2_valid = 1'b0;
    logic             in2_ready;
    logic [7:0]       in2_data = '0;
    logic             out2_valid;
    logic [3:0]       out2_count;
    logic signed [5:0] out2_disp;
    logic             out2_last;
    logic             alarm2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int first_out_cyc = -1;
    bit mon_on = 1'b0;

    exp_t q[$];
    exp_t q2[$];
    int got_disp[$];
    int got_count[$];
    bit got_last[$];
    bit got_alarm[$];
    int got2_disp[$];
    int m_acc = 0, m_win = 0, m2_acc = 0, m2_win = 0;

    bit_balance_monitor #(.WIDTH(8), .WINDOW(4), .THRESH(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_disp(out_disp), .out_last(out_last), .alarm(alarm)
    );

    bit_balance_monitor #(.WIDTH(8), .WINDOW(256), .THRESH(8), .DW(6)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data),
        .out_valid(out2_valid), .out_ready(1'b1),
        .out_count(out2_count), .out_disp(out2_disp), .out_last(out2_last), .alarm(alarm2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int width, input int window, input int thresh,
                                   input int dw, input logic [63:0] data,
                                   inout int acc, inout int win);
        exp_t e;
        int pc, s, mx;
        pc = 0;
        for (int i = 0; i < width; i++) pc += int'(data[i]);
        s  = acc + 2 * pc - width;
        mx = (1 << (dw - 1)) - 1;
        if (s > mx) s = mx;
        if (s < -mx) s = -mx;
        e.count = pc;
        e.disp  = s;
        e.alarm = (s > thresh) || (-s > thresh);
        win++;
        e.last = (win == window);
        if (e.last) begin
            acc = 0;
            win = 0;
        end else begin
            acc = s;
        end
        return e;
    endfunction

    // Scoreboard for the main instance: front of queue must be on the outputs while valid
    always @(negedge clk) begin
        if (!reset && mon_on) begin
            if (out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output count=%0d disp=%0d", out_count, out_disp);
                end else begin
                    if ({out_count, out_disp, out_last, alarm} !==
                        {4'(q[0].count), 8'(q[0].disp), q[0].last, q[0].alarm}) begin
                        bad++;
                        $display("FAIL result got cnt=%0d disp=%0d last=%0b alarm=%0b exp cnt=%0d disp=%0d last=%0b alarm=%0b",
                                 out_count, out_disp, out_last, alarm,
                                 q[0].count, q[0].disp, q[0].last, q[0].alarm);
                    end
                    if (out_ready) begin
                        if (first_out_cyc < 0) first_out_cyc = cyc;
                        got_disp.push_back(int'(out_disp));
                        got_count.push_back(int'(out_count));
                        got_last.push_back(out_last);
                        got_alarm.push_back(alarm);
                        void'(q.pop_front());
                    end
                end
            end else begin
                total++;
                if (alarm !== 1'b0) begin
                    bad++;
                    $display("FAIL alarm_unqualified got=%0b exp=0", alarm);
                end
            end
        end
    end

    // Scoreboard for the saturation instance
    always @(negedge clk) begin
        if (!reset && mon_on && out2_valid) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL sat_unexpected disp=%0d", out2_disp);
            end else begin
                if (int'(out2_disp) !== q2[0].disp || out2_last !== q2[0].last) begin
                    bad++;
                    $display("FAIL sat_result got disp=%0d last=%0b exp disp=%0d last=%0b",
                             out2_disp, out2_last, q2[0].disp, q2[0].last);
                end
                got2_disp.push_back(int'(out2_disp));
                void'(q2.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (acc_cyc < 0) acc_cyc = cyc;
            end
            n++;
        end
        @(posedge clk);
        #1;
        if (ok) begin
            q.push_back(model(8, 4, 8, 8, 64'(d), m_acc, m_win));
        end else begin
            total++;
            bad++;
            in_valid = 1'b0;
            $display("FAIL send_timeout got in_ready=0 exp=1");
        end
    endtask

    task automatic send2(input logic [7:0] d);
        in2_valid = 1'b1;
        in2_data = d;
        @(negedge clk);
        total++;
        if (in2_ready !== 1'b1) begin
            bad++;
            $display("FAIL sat_in_ready got=%0b exp=1", in2_ready);
        end
        @(posedge clk);
        #1;
        q2.push_back(model(8, 256, 8, 6, 64'(d), m2_acc, m2_win));
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        in2_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (q.size() != 0 || q2.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d exp=0", q.size() + q2.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in2_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        q2.delete();
        got_disp.delete();
        got_count.delete();
        got_last.delete();
        got_alarm.delete();
        got2_disp.delete();
        m_acc = 0; m_win = 0; m2_acc = 0; m2_win = 0;
        acc_cyc = -1;
        first_out_cyc = -1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, alarm, out_count} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL reset_state got valid=%0b ready=%0b alarm=%0b cnt=%0d exp 0 1 0 0",
                     out_valid, in_ready, alarm, out_count);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_all_ones();
        int ed[5] = '{8, 16, 24, 32, 0};
        int ec[5] = '{8, 8, 8, 8, 4};
        bit ea[5] = '{0, 1, 1, 1, 0};
        bit el[5] = '{0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) send(8'hFF);
        send(8'h0F);
        drain();
        total++;
        if (got_disp.size() != 5) begin
            bad++;
            $display("FAIL ones_count got=%0d exp=5", got_disp.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got_disp[i] != ed[i] || got_count[i] != ec[i] ||
                    got_alarm[i] != ea[i] || got_last[i] != el[i]) begin
                    bad++;
                    $display("FAIL ones_vec%0d got %0d/%0d/%0b/%0b exp %0d/%0d/%0b/%0b", i,
                             got_count[i], got_disp[i], got_alarm[i], got_last[i],
                             ec[i], ed[i], ea[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_negative();
        int ed[4] = '{-6, -10, -18, -24};
        bit ea[4] = '{0, 1, 1, 1};
        bit el[4] = '{0, 0, 0, 1};
        logic [7:0] w[4] = '{8'h01, 8'h03, 8'h00, 8'h80};
        do_reset();
        for (int i = 0; i < 4; i++) send(w[i]);
        drain();
        total++;
        if (first_out_cyc - acc_cyc != 2) begin
            bad++;
            $display("FAIL latency got=%0d exp=2", first_out_cyc - acc_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_disp.size() || got_disp[i] != ed[i] ||
                got_alarm[i] != ea[i] || got_last[i] != el[i]) begin
                bad++;
                $display("FAIL neg_vec%0d exp disp=%0d alarm=%0b last=%0b", i, ed[i], ea[i], el[i]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        do_reset();
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(i * 8'h13 + 8'h07));
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready got=%0b exp=0", in_ready);
                end
                @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        drain();
        total++;
        if (got_disp.size() != 8) begin
            bad++;
            $display("FAIL stall_words got=%0d exp=8", got_disp.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'hFF);
        send(8'hFF);
        drain();
        send(8'hFF);
        send(8'hFF);
        do_reset();
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL mid_reset got valid=%0b ready=%0b exp 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 4; i++) send(8'hFF);
        drain();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_disp.size() || got_disp[i] != 8 * (i + 1) || got_last[i] != (i == 3)) begin
                bad++;
                $display("FAIL mid_vec%0d exp disp=%0d last=%0b", i, 8 * (i + 1), (i == 3));
            end
        end
    endtask

    task automatic test_saturation();
        int ed[6] = '{8, 16, 24, 31, 31, 23};
        do_reset();
        for (int i = 0; i < 5; i++) send2(8'hFF);
        send2(8'h00);
        drain();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= got2_disp.size() || got2_disp[i] != ed[i]) begin
                bad++;
                $display("FAIL sat_vec%0d exp disp=%0d", i, ed[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_negative();
        test_back_to_back_stall();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
